wino_tile_feeder: RTL

// - Producer side of the Winograd F(2x2,3x3) data-tile interface. Accepts a raster pixel stream of one
//   IMG_H x IMG_W feature map and emits overlapping 4x4 tiles (stride 2) on the 128-bit data port

---
 rtl/wino_tile_feeder.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/wino_tile_feeder.sv
// -----------------------------------------------------------------------------
// wino_tile_feeder
// Producer side of the Winograd F(2x2,3x3) data-tile interface. Takes one
// IMG_H x IMG_W feature map as a raster pixel stream and emits overlapping
// 4x4 tiles (stride 2) for the data-transform stage. Four image rows live in a
// circular line buffer (image row r in slot r%4); input is stalled while a
// tile row is being emitted, so no live row is ever overwritten.
//
// Optional build macro:
//   WINO_PAD_EN  - apply a 1-pixel zero border (virtual (IMG_H+2)x(IMG_W+2)
//                  image, IMG_H/2 x IMG_W/2 tiles). Undefined: valid-only
//                  tiling, (IMG_H-2)/2 x (IMG_W-2)/2 tiles.
//
// Ports:
//   clk        in   clock, rising edge
//   rstn       in   asynchronous active-low reset
//   s_valid    in   input pixel valid
//   s_ready    out  feeder accepts a pixel
//   s_pixel    in   pixel [W-1:0], raster order
//   tile_valid out  tile_data holds a tile
//   tile_ready in   downstream accepts the tile
//   tile_data  out  4x4 tile, element (r,c) at [(15-(4r+c))*W +: W]
//   tile_row   out  tile-row index of the current tile
//   tile_col   out  tile-column index of the current tile
//   frame_done out  one-cycle pulse after the last tile of a frame handshakes
// -----------------------------------------------------------------------------
module wino_tile_feeder #(
    parameter int W     = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [W-1:0]    s_pixel,
    output logic            tile_valid,
    input  logic            tile_ready,
    output logic [16*W-1:0] tile_data,
    output logic [7:0]      tile_row,
    output logic [7:0]      tile_col,
    output logic            frame_done
);

`ifdef WINO_PAD_EN
    localparam int TILE_ROWS = IMG_H / 2;
    localparam int TILE_COLS = IMG_W / 2;
    localparam int ORIGIN    = 1;   // tile (0,0) starts at real row/col -1
`else
    localparam int TILE_ROWS = (IMG_H - 2) / 2;
    localparam int TILE_COLS = (IMG_W - 2) / 2;
    localparam int ORIGIN    = 0;
`endif
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [15:0]       pix_row_r;     // rows completed so far == row being filled
    logic [15:0]       pix_col_r;
    logic [7:0]        tile_row_r;
    logic [7:0]        tile_col_r;
    logic              s_ready_r;
    logic              tile_valid_r;
    logic [16*W-1:0]   tile_data_r;
    logic              frame_done_r;
    logic [W-1:0]      lb_r [4][IMG_W];

    logic              pix_acc_s;
    logic [7:0]        nxt_t_s;
    logic [7:0]        nxt_k_s;
    logic [16*W-1:0]   gather_s;

    // Index of the last real image row that tile row t depends on.
    function automatic logic [15:0] last_row_f(input logic [7:0] t);
        int v;
`ifdef WINO_PAD_EN
        v = 2 * int'(t) + 2;
        if (v > IMG_H - 1) begin
            v = IMG_H - 1;
        end else begin
            v = v;
        end
`else
        v = 2 * int'(t) + 3;
`endif
        return 16'(v);
    endfunction

    assign pix_acc_s = s_valid && s_ready_r;

    // Coordinates of the tile that will be loaded at the next load event.
    always_comb begin
        nxt_t_s = tile_row_r;
        nxt_k_s = 8'd0;
        if (state_r == ST_EMIT) begin
            if (tile_col_r == 8'(TILE_COLS - 1)) begin
                nxt_t_s = tile_row_r + 8'd1;
                nxt_k_s = 8'd0;
            end else begin
                nxt_t_s = tile_row_r;
                nxt_k_s = tile_col_r + 8'd1;
            end
        end else begin
            nxt_t_s = tile_row_r;
            nxt_k_s = 8'd0;
        end
    end

    // Assemble the next tile from the line buffer; the pixel being written
    // this cycle is forwarded because EMIT entry loads on the same edge.
    always_comb begin
        gather_s = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                automatic int           src_row = 2 * int'(nxt_t_s) + i - ORIGIN;
                automatic int           src_col = 2 * int'(nxt_k_s) + j - ORIGIN;
                automatic logic [1:0]   slot_v  = src_row[1:0];
                automatic logic [CW-1:0] col_v  = src_col[CW-1:0];
                automatic logic         fwd_v;
                automatic logic [W-1:0] elem_v;
                fwd_v  = pix_acc_s && (pix_row_r[1:0] == slot_v) &&
                         (pix_col_r == 16'(src_col));
                elem_v = fwd_v ? s_pixel : lb_r[slot_v][col_v];
`ifdef WINO_PAD_EN
                elem_v = ((src_row >= 0) && (src_row < IMG_H) &&
                          (src_col >= 0) && (src_col < IMG_W)) ? elem_v : {W{1'b0}};
`endif
                gather_s[(15 - (4 * i + j)) * W +: W] = elem_v;
            end
        end
    end

    // Line buffer write port (storage only, deliberately not reset).
    always_ff @(posedge clk) begin
        if (pix_acc_s) begin
            lb_r[pix_row_r[1:0]][pix_col_r[CW-1:0]] <= s_pixel;
        end
    end

    // Control FSM: pixel/tile counters and all registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r      <= ST_FILL;
            pix_row_r    <= 16'd0;
            pix_col_r    <= 16'd0;
            tile_row_r   <= 8'd0;
            tile_col_r   <= 8'd0;
            s_ready_r    <= 1'b0;
            tile_valid_r <= 1'b0;
            tile_data_r  <= '0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_FILL: begin
                    s_ready_r    <= 1'b1;
                    tile_valid_r <= 1'b0;
                    if (pix_acc_s) begin
                        if (pix_col_r == 16'(IMG_W - 1)) begin
                            pix_col_r <= 16'd0;
                            pix_row_r <= pix_row_r + 16'd1;
                            // Row completing the window for this tile row.
                            if (pix_row_r == last_row_f(tile_row_r)) begin
                                state_r      <= ST_EMIT;
                                s_ready_r    <= 1'b0;
                                tile_valid_r <= 1'b1;
                                tile_data_r  <= gather_s;
                                tile_col_r   <= 8'd0;
                            end
                        end else begin
                            pix_col_r <= pix_col_r + 16'd1;
                        end
                    end
                end
                ST_EMIT: begin
                    s_ready_r <= 1'b0;
                    if (tile_ready) begin
                        if (tile_col_r == 8'(TILE_COLS - 1)) begin
                            if (tile_row_r == 8'(TILE_ROWS - 1)) begin
                                frame_done_r <= 1'b1;
                                pix_row_r    <= 16'd0;
                                pix_col_r    <= 16'd0;
                                tile_row_r   <= 8'd0;
                                tile_col_r   <= 8'd0;
                                state_r      <= ST_FILL;
                                tile_valid_r <= 1'b0;
                                s_ready_r    <= 1'b1;
                            end else begin
                                tile_row_r <= tile_row_r + 8'd1;
                                tile_col_r <= 8'd0;
                                // Next tile row may already be fully buffered.
                                if (pix_row_r > last_row_f(tile_row_r + 8'd1)) begin
                                    tile_data_r <= gather_s;
                                end else begin
                                    state_r      <= ST_FILL;
                                    tile_valid_r <= 1'b0;
                                    s_ready_r    <= 1'b1;
                                end
                            end
                        end else begin
                            tile_col_r  <= tile_col_r + 8'd1;
                            tile_data_r <= gather_s;
                        end
                    end
                end
                default: begin
                    state_r      <= ST_FILL;
                    tile_valid_r <= 1'b0;
                    s_ready_r    <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = s_ready_r;
    assign tile_valid = tile_valid_r;
    assign tile_data  = tile_data_r;
    assign tile_row   = tile_row_r;
    assign tile_col   = tile_col_r;
    assign frame_done = frame_done_r;

endmodule
